// File: rtl/ring_buffer_ctrl.sv
// ring_buffer_ctrl
// ----------------
// Byte-wide random-access front end for an 8-bit serial recirculating ring
// store of WORD_COUNT words (N = WORD_COUNT*8 bit slots). A free-running
// position counter tracks which ring slot is at the tail. An accepted request
// waits for the addressed word to come round. The block then drives 8 cycles
// of serial write/capture, MSB first, and issues a one-cycle response
// carrying the byte that was in the slot before the access.
//
// Ports:
//   clk        in   ring shifts on every rising edge
//   reset      in   asynchronous active-low reset (shared with the ring)
//   req_valid  in   request present
//   req_ready  out  request can be accepted (IDLE only)
//   req_write  in   1 = write, 0 = read
//   req_addr   in   word address
//   req_wdata  in   write byte
//   rsp_valid  out  one-cycle response pulse
//   rsp_rdata  out  previous slot contents; held until the next response
//   ring_write out  replace the recirculating bit with ring_din this cycle
//   ring_din   out  serial data bit to the ring
//   ring_tail  in   bit about to recirculate (slot at current position)
//   busy       out  high while a request is in flight (SEEK/XFER/RESP)

module ring_buffer_ctrl #(
  parameter int WORD_COUNT = 64,
  parameter int ADDR_W     = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [7:0]        req_wdata,
  output logic              rsp_valid,
  output logic [7:0]        rsp_rdata,
  output logic              ring_write,
  output logic              ring_din,
  input  logic              ring_tail,
  output logic              busy
);

  // Position width covers every bit slot of the ring; wraps modulo N for free.
  localparam int POS_W = $clog2(WORD_COUNT) + 3;
  localparam logic [POS_W-1:0] POS_ONE = {{(POS_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEEK = 2'd1,
    ST_XFER = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [POS_W-1:0]  pos_q, pos_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic [6:0]        cap_q, cap_d;
  logic [7:0]        rdata_q, rdata_d;
  logic [POS_W-1:0]  pos_next_s;

  // Position of the slot that will be at the tail in the next cycle.
  assign pos_next_s = pos_q + POS_ONE;

  // Next-state and datapath update for the request sequencer.
  always_comb begin
    state_d = state_q;
    pos_d   = pos_next_s;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cap_d   = cap_q;
    rdata_d = rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          write_d = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          // If the addressed word starts in the very next cycle, skip SEEK
          // so that acceptance at 8*addr-1 transfers immediately.
          if (pos_next_s == {req_addr, 3'b000}) begin
            state_d = ST_XFER;
          end else begin
            state_d = ST_SEEK;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_SEEK: begin
        if (pos_next_s == {addr_q, 3'b000}) begin
          state_d = ST_XFER;
        end else begin
          state_d = ST_SEEK;
        end
      end

      ST_XFER: begin
        // Only the first seven bits need holding; the eighth arrives live
        // on ring_tail in the last transfer cycle.
        cap_d = {cap_q[5:0], ring_tail};
        if (pos_q[2:0] == 3'd7) begin
          rdata_d = {cap_q, ring_tail};
          state_d = ST_RESP;
        end else begin
          state_d = ST_XFER;
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, position and request registers; reset leaves ring contents alone.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      pos_q   <= {POS_W{1'b0}};
      write_q <= 1'b0;
      addr_q  <= {ADDR_W{1'b0}};
      wdata_q <= 8'h00;
      cap_q   <= 7'h00;
      rdata_q <= 8'h00;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cap_q   <= cap_d;
      rdata_q <= rdata_d;
    end
  end

  // Moore outputs decoded from registers only, so reset clears them at once.
  // During XFER pos_q[2:0] is the bit index k; bit 7-k equals bit ~k.
  assign req_ready  = (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign rsp_valid  = (state_q == ST_RESP);
  assign rsp_rdata  = rdata_q;
  assign ring_write = (state_q == ST_XFER) && write_q;
  assign ring_din   = ring_write && wdata_q[~pos_q[2:0]];

endmodule

// File: doc/ring_buffer_ctrl.md
Name: ring_buffer_ctrl

Overview:
- Byte-wide, random-access request/response front end for the 8-bit serial recirculating ring store.
- The ring is WORD_COUNT×8 bits long. It shifts one bit per clock, takes a write strobe and data bit, and exposes its tail bit.
- This block tracks ring rotation, waits for the addressed word to come round, and then drives 8 cycles of serial write/capture.
- It sits between the pad/host logic and the ring, and serialises one request at a time.

Parameters:
- WORD_COUNT, 64, number of 8-bit words in the ring; must be a power of 2, ≥2.
- ADDR_W, 6, word address width; must equal log2(WORD_COUNT).

Ports:
- clk  in  1  single clock; ring shifts on every rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request (high only in IDLE).
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  8  write byte.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  8  byte held in the slot before this access (read data, or the old value on a write).
- ring_write  out  1  to ring: replace the recirculating bit with ring_din this cycle.
- ring_din  out  1  to ring: serial data bit.
- ring_tail  in  1  from ring: current MSB (the bit about to recirculate).
- busy  out  1  high in SEEK, XFER and RESP.

Behaviour:
- N = WORD_COUNT*8. Position counter pos, width log2(N):
  - resets to 0;
  - increments modulo N every cycle, in all states;
  - must share reset with the ring so that pos stays aligned to ring bit slots.
- Slot model: in the cycle with pos = p, ring_tail is the bit last written in slot p.
  - At the edge ending that cycle, the ring stores ring_din if ring_write = 1; otherwise it stores ring_tail.
- Word w occupies pos 8w..8w+7, MSB first: pos 8w carries bit 7, pos 8w+7 carries bit 0.
- States: IDLE, SEEK, XFER, RESP. All outputs are decoded from registers only (Moore).
- IDLE:
  - req_ready = 1.
  - A handshake (req_valid & req_ready at an edge) latches write, addr, wdata and moves to SEEK.
- SEEK:
  - Moves to XFER at the edge after which pos will equal 8*addr.
  - Acceptance in a cycle with pos = 8*addr−1 (mod N) gives XFER on the next cycle.
  - Acceptance with pos = 8*addr waits a full N cycles.
  - Maximum request-to-first-XFER latency is N cycles.
- XFER lasts exactly 8 cycles, with k = 0..7 and pos = 8*addr+k:
  - ring_write = latched write;
  - ring_din = wdata[7−k] on writes, 0 otherwise;
  - ring_tail is shifted into a capture register (MSB first) every XFER cycle.
- RESP (1 cycle):
  - rsp_valid = 1 and rsp_rdata = captured byte;
  - then IDLE.
  - req_ready = 0 in RESP, so the earliest next acceptance is in the following cycle.
- rsp_rdata holds its last value until the next RESP. It is 0x00 after reset.
- Wrap-around: word WORD_COUNT−1 ends at pos N−1. RESP then occurs at pos 0; no special casing is needed.
- Inputs are ignored outside IDLE. req_* may change freely once accepted.
- Reset assertion at any time, including mid-XFER, immediately forces:
  - state = IDLE, pos = 0;
  - ring_write = 0, ring_din = 0, rsp_valid = 0, rsp_rdata = 0x00;
  - busy = 0, req_ready = 1.
- No response is issued for an aborted request. A partially written word is left as is; ring contents are not cleared.
- Reset values: req_ready = 1; all other outputs 0.

Test Plan:
(WORD_COUNT = 64, N = 512; the bench contains a behavioural ring model.)
1. Reset, then 20 idle cycles -> req_ready = 1; ring_write, rsp_valid and busy = 0; ring model contents unchanged (pure recirculation).
2. Write addr 3, 0xA5, accepted at pos 23 -> ring_write high exactly at pos 24..31, ring_din = 1,0,1,0,0,1,0,1; rsp_valid pulse at pos 32; model word 3 = 0xA5.
3. Read addr 3, accepted at pos 24 -> waits 512 cycles; rsp_rdata = 0xA5; ring_write never asserted; all other words unchanged.
4. Write addr 3, 0x3C -> rsp_rdata = 0xA5 (old value); a subsequent read of addr 3 returns 0x3C.
5. Write addr 63, 0xFF, accepted at pos 0 -> XFER at pos 504..511; rsp_valid at pos 0 after wrap. Request held during RESP is accepted only the next cycle.
6. Assert reset during XFER at k = 3 -> ring_write = 0 and busy = 0 immediately; pos = 0; no rsp_valid. After release, a read of the same word returns the upper 3 new bits and the lower 5 old bits.
